// File: rtl/robot_nav_if.sv
// Sensor pins and motor-drive outputs of the wall-following navigation controller.
// Defining ROBOT_ODOMETER_EN adds the 16-bit odometer to the bundle.
interface robot_nav_if;
  logic head;
  logic left;
  logic clear;
  logic front;
  logic rotate;
  logic rotate_left;
  logic stuck;
`ifdef ROBOT_ODOMETER_EN
  logic [15:0] odometer;

  modport master (output head, left, clear,
                  input  front, rotate, rotate_left, stuck, odometer);
  modport slave  (input  head, left, clear,
                  output front, rotate, rotate_left, stuck, odometer);
`else
  modport master (output head, left, clear,
                  input  front, rotate, rotate_left, stuck);
  modport slave  (input  head, left, clear,
                  output front, rotate, rotate_left, stuck);
`endif
endinterface

// File: rtl/robot_nav_fsm.sv
// Wall-following robot controller: step-tick divider, sensor sync/debounce, timed turns, stuck detect.
// MEALY selects registered or head-gated outputs; define ROBOT_ODOMETER_EN to add the odometer.
module robot_nav_fsm #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned DEBOUNCE  = 3,
  parameter int unsigned ROT_TICKS = 4,
  parameter int unsigned ADV_TICKS = 2,
  parameter int unsigned MAX_TURNS = 4,
  parameter int unsigned MEALY     = 0
) (
  input logic        clk,
  input logic        reset_n,
  robot_nav_if.slave nav
);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TMR_MAX = (ROT_TICKS > ADV_TICKS) ? ROT_TICKS : ADV_TICKS;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned TC_W    = $clog2(MAX_TURNS + 1);

  localparam logic [2:0] SEARCH = 3'd0;
  localparam logic [2:0] FOLLOW = 3'd1;
  localparam logic [2:0] ADV    = 3'd2;
  localparam logic [2:0] TURN_L = 3'd3;
  localparam logic [2:0] TURN_R = 3'd4;
  localparam logic [2:0] STUCK  = 3'd5;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       sync1, sync2, filt;
  logic             head_f, left_f;
  logic [2:0]       state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [TC_W-1:0]  turn_cnt, turn_cnt_nx;
  logic             turn_r_req;
  logic             front_q, rotate_q, rotate_left_q, stuck_q;
  logic             head_gate;
  logic             front_o;

  // Step tick divider
  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Two-flop synchronisers; bit 0 = head, bit 1 = left
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {nav.left, nav.head};
      sync2 <= sync1;
    end
  end

  if (DEBOUNCE == 0) begin : g_bypass
    assign filt = sync2;
  end else begin : g_debounce
    localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    for (genvar i = 0; i < 2; i++) begin : g_ch
      logic [DB_W-1:0] cnt;
      logic            q;
      // Flip only after DEBOUNCE consecutive differing samples
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt <= '0;
          q   <= 1'b0;
        end else if (sync2[i] == q) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
          cnt <= '0;
          q   <= sync2[i];
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
      assign filt[i] = q;
    end
  end

  assign head_f = filt[0];
  assign left_f = filt[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= SEARCH;
      timer    <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      turn_cnt <= turn_cnt_nx;
    end
  end

  // Next state, timers and turn counter; head_f takes priority over left_f
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    turn_cnt_nx = turn_cnt;
    turn_r_req  = 1'b0;
    if (tick) begin
      case (state)
        SEARCH: begin
          if (head_f)      turn_r_req = 1'b1;
          else if (left_f) state_nx   = FOLLOW;
        end
        FOLLOW: begin
          if (head_f) begin
            turn_r_req = 1'b1;
          end else if (!left_f) begin
            state_nx = ADV;
            timer_nx = TMR_W'(ADV_TICKS - 1);
          end else begin
            turn_cnt_nx = '0;
          end
        end
        ADV: begin
          if (head_f) begin
            turn_r_req = 1'b1;
          end else if (timer == '0) begin
            state_nx = TURN_L;
            timer_nx = TMR_W'(ROT_TICKS - 1);
          end else begin
            timer_nx = timer - TMR_W'(1);
          end
        end
        TURN_L: begin
          if (timer == '0) state_nx = left_f ? FOLLOW : SEARCH;
          else             timer_nx = timer - TMR_W'(1);
        end
        TURN_R: begin
          if (timer != '0)  timer_nx   = timer - TMR_W'(1);
          else if (head_f)  turn_r_req = 1'b1;
          else              state_nx   = left_f ? FOLLOW : SEARCH;
        end
        STUCK: begin
          if (nav.clear) begin
            state_nx    = SEARCH;
            turn_cnt_nx = '0;
          end
        end
        default: state_nx = SEARCH;
      endcase
      // A right turn that would reach MAX_TURNS declares STUCK instead
      if (turn_r_req) begin
        if (turn_cnt >= TC_W'(MAX_TURNS - 1)) begin
          state_nx    = STUCK;
          turn_cnt_nx = TC_W'(MAX_TURNS);
        end else begin
          state_nx    = TURN_R;
          timer_nx    = TMR_W'(ROT_TICKS - 1);
          turn_cnt_nx = turn_cnt + TC_W'(1);
        end
      end
    end
  end

  // Outputs decoded from next state so they move together with the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      front_q       <= 1'b0;
      rotate_q      <= 1'b0;
      rotate_left_q <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      front_q       <= (state_nx == SEARCH) || (state_nx == FOLLOW) || (state_nx == ADV);
      rotate_q      <= (state_nx == TURN_R);
      rotate_left_q <= (state_nx == TURN_L);
      stuck_q       <= (state_nx == STUCK);
    end
  end

  if (MEALY != 0) begin : g_mealy
    assign head_gate = head_f && ((state == SEARCH) || (state == FOLLOW) || (state == ADV));
  end else begin : g_moore
    assign head_gate = 1'b0;
  end

  assign front_o         = front_q & ~head_gate;
  assign nav.front       = front_o;
  assign nav.rotate      = rotate_q | head_gate;
  assign nav.rotate_left = rotate_left_q;
  assign nav.stuck       = stuck_q;

`ifdef ROBOT_ODOMETER_EN
  logic [15:0] odo_q;

  // Forward-tick odometer, wraps naturally; only reset clears it
  always_ff @(posedge clk) begin
    if (!reset_n)             odo_q <= '0;
    else if (tick && front_o) odo_q <= odo_q + 16'd1;
  end

  assign nav.odometer = odo_q;
`endif
endmodule
